// File: rtl/ckegen_multi_if.sv
// Control and status bundle for the multi-channel clock-enable generator.
// The master drives the enables, modes and divisor writes; the slave returns the pulses and busy flags.
interface ckegen_multi_if #(
  parameter int N = 4,
  parameter int W = 32
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  ena;
  logic [N-1:0]  oneshot;
  logic          div_we;
  logic [SW-1:0] div_sel;
  logic [W-1:0]  div_val;
  logic [N-1:0]  gen;
  logic [N-1:0]  busy;

  modport master (
    output ena, oneshot, div_we, div_sel, div_val,
    input  gen, busy
  );

  modport slave (
    input  ena, oneshot, div_we, div_sel, div_val,
    output gen, busy
  );
endinterface

// File: rtl/ckegen_multi.sv
// N independent, runtime-programmable enable generators (periodic or one-shot) sharing one clock.
// Divisor writes land in a shadow register and reach the active divisor only while idle or at a wrap.
module ckegen_multi #(
  parameter int N           = 4,
  parameter int W           = 32,
  parameter int DEFAULT_DIV = 50000000
) (
  input  logic         clk,
  input  logic         rst,
  ckegen_multi_if.slave cke
);

  localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);
  localparam logic [W-1:0] ONE     = W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      state_e       state_q, state_d;
      logic [W-1:0] cnt_q, cnt_d;
      logic [W-1:0] div_sh_q, div_sh_d;
      logic [W-1:0] div_a_q, div_a_d;
      logic         mode_q, mode_d;
      logic         gen_c, busy_c;

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          div_sh_q <= DEF_DIV;
          div_a_q  <= DEF_DIV;
          mode_q   <= 1'b0;
        end else begin
          state_q  <= state_d;
          cnt_q    <= cnt_d;
          div_sh_q <= div_sh_d;
          div_a_q  <= div_a_d;
          mode_q   <= mode_d;
        end
      end

      always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_sh_d = div_sh_q;
        div_a_d  = div_a_q;
        mode_d   = mode_q;

        // Zero is promoted to 1 so the wrap compare (div_a-1) can never underflow.
        if (cke.div_we && (32'(cke.div_sel) == gi)) begin
          div_sh_d = (cke.div_val == '0) ? ONE : cke.div_val;
        end

        case (state_q)
          IDLE: begin
            div_a_d = div_sh_q;
            cnt_d   = '0;
            if (cke.ena[gi]) begin
              mode_d = cke.oneshot[gi];
              // Decide on the divisor being loaded now, not the stale active copy.
              if (div_sh_q == ONE) begin
                state_d = cke.oneshot[gi] ? DONE : RUN;
              end else begin
                state_d = RUN;
                cnt_d   = ONE;
              end
            end
          end
          RUN: begin
            if (!cke.ena[gi]) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else if (cnt_q == div_a_q - ONE) begin
              cnt_d = '0;
              if (mode_q) begin
                state_d = DONE;
              end else begin
                div_a_d = div_sh_q;
              end
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end
          DONE: begin
            if (!cke.ena[gi]) begin
              state_d = IDLE;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end

      always_comb begin
        gen_c  = !rst && cke.ena[gi] && (cnt_q == '0) && (state_q != DONE);
        busy_c = !rst && (((state_q == IDLE) && cke.ena[gi]) || (state_q == RUN));
      end

      assign cke.gen[gi]  = gen_c;
      assign cke.busy[gi] = busy_c;
    end
  endgenerate

endmodule

// File: tb/tb_ckegen_multi.sv
// Directed bench for ckegen_multi: per-cycle gen/busy checks against hand-derived pulse schedules.
// A second 5-channel instance exercises channel selects that fall outside the channel range.
module tb_ckegen_multi;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ckegen_multi_if #(.N(4), .W(8)) cif ();
  ckegen_multi #(.N(4), .W(8), .DEFAULT_DIV(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .cke (cif)
  );

  ckegen_multi_if #(.N(5), .W(8)) cif5 ();
  ckegen_multi #(.N(5), .W(8), .DEFAULT_DIV(4)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .cke (cif5)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s: %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cif.ena      = '0;
    cif.oneshot  = '0;
    cif.div_we   = 1'b0;
    cif.div_sel  = '0;
    cif.div_val  = '0;
    cif5.ena     = '0;
    cif5.oneshot = '0;
    cif5.div_we  = 1'b0;
    cif5.div_sel = '0;
    cif5.div_val = '0;
  endtask

  // Leaves the bench #1 after the first edge with rst low: that cycle is cycle 0.
  task automatic reset_dut();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    next_cycle();

    // Outputs forced low during reset even with every channel enabled.
    cif.ena = 4'hf;
    @(negedge clk);
    check("rst gen forced 0", 32'(cif.gen), 32'h0);
    check("rst busy forced 0", 32'(cif.busy), 32'h0);
    reset_dut();
    @(negedge clk);
    check("idle gen", 32'(cif.gen), 32'h0);
    check("idle busy", 32'(cif.busy), 32'h0);

    // Default divisor 4 on channel 0.
    reset_dut();
    cif.ena = 4'b0001;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check($sformatf("t1 gen c%0d", c), 32'(cif.gen), (c % 4 == 0) ? 32'h1 : 32'h0);
      check($sformatf("t1 busy c%0d", c), 32'(cif.busy), 32'h1);
      next_cycle();
    end

    // Divisor 3 written at cycle 1 takes effect after the wrap at cycle 3.
    reset_dut();
    cif.ena = 4'b0010;
    for (int c = 0; c < 14; c++) begin
      cif.div_we  = (c == 1);
      cif.div_sel = 2'd1;
      cif.div_val = 8'd3;
      @(negedge clk);
      check($sformatf("t2 gen c%0d", c), 32'(cif.gen),
            (c == 0 || c == 4 || (c > 4 && (c - 4) % 3 == 0)) ? 32'h2 : 32'h0);
      next_cycle();
    end
    cif.div_we = 1'b0;

    // Divisor 0 is treated as 1: continuous enable.
    reset_dut();
    for (int c = 0; c < 9; c++) begin
      cif.div_we  = (c == 0);
      cif.div_sel = 2'd2;
      cif.div_val = 8'd0;
      cif.ena     = (c >= 1) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      check($sformatf("t3 gen c%0d", c), 32'(cif.gen), (c >= 1) ? 32'h4 : 32'h0);
      check($sformatf("t3 busy c%0d", c), 32'(cif.busy), (c >= 1) ? 32'h4 : 32'h0);
      next_cycle();
    end
    cif.div_we = 1'b0;

    // One-shot on channel 3; mode changes mid-run are ignored; re-arm after one low cycle.
    reset_dut();
    for (int c = 0; c < 16; c++) begin
      cif.ena     = (c != 10) ? 4'b1000 : 4'b0000;
      cif.oneshot = (c >= 1 && c <= 8) ? 4'b0000 : 4'b1000;
      @(negedge clk);
      check($sformatf("t4 gen c%0d", c), 32'(cif.gen), (c == 0 || c == 11) ? 32'h8 : 32'h0);
      check($sformatf("t4 busy c%0d", c), 32'(cif.busy),
            (c <= 3 || (c >= 11 && c <= 14)) ? 32'h8 : 32'h0);
      next_cycle();
    end

    // Enable dropped at 6-7 abandons the period; restart on re-enable.
    reset_dut();
    for (int c = 0; c < 16; c++) begin
      cif.ena = (c <= 5 || c >= 8) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      check($sformatf("t5 gen c%0d", c), 32'(cif.gen), (c % 4 == 0) ? 32'h1 : 32'h0);
      check($sformatf("t5 busy c%0d", c), 32'(cif.busy), (c == 7) ? 32'h0 : 32'h1);
      next_cycle();
    end

    // Divisor 7 written while running, then reset mid-period restores the default.
    reset_dut();
    cif.ena = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      cif.div_we  = (c == 1);
      cif.div_sel = 2'd0;
      cif.div_val = 8'd7;
      @(negedge clk);
      check($sformatf("t6 pre gen c%0d", c), 32'(cif.gen), (c % 4 == 0) ? 32'h1 : 32'h0);
      next_cycle();
    end
    cif.div_we = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6 gen in rst", 32'(cif.gen), 32'h0);
    check("t6 busy in rst", 32'(cif.busy), 32'h0);
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      check($sformatf("t6 post gen c%0d", c), 32'(cif.gen), (c % 4 == 0) ? 32'h1 : 32'h0);
      next_cycle();
    end

    // Out-of-range selects 5..7 on the 5-channel instance change nothing.
    reset_dut();
    cif5.ena = 5'h1f;
    for (int c = 0; c < 10; c++) begin
      cif5.div_we  = (c <= 2);
      cif5.div_sel = 3'(5 + c);
      cif5.div_val = 8'd1;
      @(negedge clk);
      check($sformatf("t7 gen c%0d", c), 32'(cif5.gen), (c % 4 == 0) ? 32'h1f : 32'h0);
      next_cycle();
    end
    cif5.div_we = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
